// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR datapath dimensions.
//   NB_IN      - FIR input sample width
//   NB_COEFFS  - coefficient width
//   N_COEFFS   - number of taps
//   NB_FIR_OUT - full-precision FIR output width (NB_IN + NB_COEFFS + clog2(N_COEFFS))
package fir_pkg;

    localparam int NB_IN      = 8;
    localparam int NB_COEFFS  = 8;
    localparam int N_COEFFS   = 8;
    localparam int NB_FIR_OUT = NB_IN + NB_COEFFS + $clog2(N_COEFFS);

endpackage

// File: rtl/fir_out_quant_fifo.sv
// fir_oq_fifo: first-word-fall-through FIFO for the quantized FIR output.
//   i_clock    - clock, all state on rising edge
//   i_reset    - asynchronous active-high reset (empties the FIFO)
//   i_wr       - write request; dropped when full unless a pop happens the same cycle
//   i_wdata    - write data
//   i_rd       - read request; pops only when not empty
//   o_rdata    - FIFO head, combinational from storage (0 when empty)
//   o_empty    - FIFO empty
//   o_full     - FIFO full
//   o_overflow - single-cycle pulse: a write was dropped
module fir_oq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;
    logic             push;

    // Extra MSB on each pointer distinguishes full from empty when indices match.
    always_comb begin
        o_empty    = (wr_ptr == rd_ptr);
        o_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop        = i_rd && !o_empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
        push       = i_wr && (!o_full || pop);
        o_overflow = i_wr && o_full && !pop;
        o_rdata    = o_empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/fir_out_quant.sv
// fir_out_quant: decimates, rounds (half-up) and quantizes FIR output samples,
// buffering the results in a small FWFT FIFO with valid/ready output.
//   i_clock    - clock, all state on rising edge
//   i_reset    - asynchronous active-high reset
//   i_data     - signed FIR output sample (NB_DATA_IN bits)
//   i_valid    - i_data valid this cycle (no input backpressure)
//   i_decim    - decimation factor (0 treated as 1), latched at period start
//   o_data     - signed quantized sample at FIFO head (NB_OUT bits)
//   o_valid    - FIFO not empty
//   i_ready    - consumer accepts o_data when o_valid && i_ready
//   o_overflow - sticky: a kept sample was dropped on a full FIFO
//   o_sat      - sticky: at least one kept sample was clamped
// Build option: define FIR_OQ_SAT_EN to clamp to the NB_OUT range instead of
// wrapping; without it o_sat stays 0.
module fir_out_quant
    import fir_pkg::*;
#(
    parameter int NB_DATA_IN = NB_FIR_OUT,
    parameter int NB_OUT     = 8,
    parameter int NB_DROP    = 11,
    parameter int FIFO_DEPTH = 4,
    parameter int NB_DECIM   = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [NB_DATA_IN-1:0] i_data,
    input  logic                  i_valid,
    input  logic [NB_DECIM-1:0]   i_decim,
    output logic [NB_OUT-1:0]     o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_overflow,
    output logic                  o_sat
);

    localparam int NB_SUM = NB_DATA_IN + 1;
    localparam int NB_RND = NB_SUM - NB_DROP;
    localparam logic [NB_SUM-1:0] HALF = NB_SUM'(1) << (NB_DROP - 1);

    logic [NB_DECIM-1:0] cnt;
    logic [NB_DECIM-1:0] act;
    logic [NB_DECIM-1:0] dec_f;
    logic [NB_SUM-1:0]   sum;
    logic [NB_RND-1:0]   rnd;
    logic [NB_OUT-1:0]   qval;
    logic                qsat;

    logic                pipe_keep;
    logic [NB_OUT-1:0]   pipe_data;
    logic                pipe_sat;

    logic                fifo_empty;
    logic                fifo_full;
    logic                fifo_ovf;
    logic                unused_bits;

    // Sign-extend by one bit before adding the half LSB so the sum cannot overflow;
    // taking the upper bits is the arithmetic right shift by NB_DROP.
    always_comb begin
        dec_f = (i_decim == '0) ? NB_DECIM'(1) : i_decim;
        sum   = {i_data[NB_DATA_IN-1], i_data} + HALF;
        rnd   = sum[NB_SUM-1:NB_DROP];
    end

`ifdef FIR_OQ_SAT_EN
    localparam logic [NB_RND-1:0] MAXV = {{(NB_RND - NB_OUT + 1){1'b0}}, {(NB_OUT - 1){1'b1}}};
    localparam logic [NB_RND-1:0] MINV = ~MAXV;

    always_comb begin
        qval = rnd[NB_OUT-1:0];
        qsat = 1'b0;
        if ($signed(rnd) > $signed(MAXV)) begin
            qval = MAXV[NB_OUT-1:0];
            qsat = 1'b1;
        end else if ($signed(rnd) < $signed(MINV)) begin
            qval = MINV[NB_OUT-1:0];
            qsat = 1'b1;
        end
    end

    assign unused_bits = ^{sum[NB_DROP-1:0]};
`else
    always_comb begin
        qval = rnd[NB_OUT-1:0];
        qsat = 1'b0;
    end

    assign unused_bits = ^{sum[NB_DROP-1:0], rnd[NB_RND-1:NB_OUT]};
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt        <= '0;
            act        <= NB_DECIM'(1);
            pipe_keep  <= 1'b0;
            pipe_data  <= '0;
            pipe_sat   <= 1'b0;
            o_overflow <= 1'b0;
            o_sat      <= 1'b0;
        end else begin
            pipe_keep <= 1'b0;
            if (i_valid) begin
                if (cnt == '0) begin
                    // Period start: keep this sample and pick up the new factor.
                    act       <= dec_f;
                    cnt       <= (dec_f == NB_DECIM'(1)) ? '0 : NB_DECIM'(1);
                    pipe_keep <= 1'b1;
                    pipe_data <= qval;
                    pipe_sat  <= qsat;
                end else begin
                    cnt <= (cnt == act - NB_DECIM'(1)) ? '0 : cnt + NB_DECIM'(1);
                end
            end
            if (pipe_keep && pipe_sat) begin
                o_sat <= 1'b1;
            end
            if (fifo_ovf) begin
                o_overflow <= 1'b1;
            end
        end
    end

    fir_oq_fifo #(
        .WIDTH (NB_OUT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_wr       (pipe_keep),
        .i_wdata    (pipe_data),
        .i_rd       (i_ready),
        .o_rdata    (o_data),
        .o_empty    (fifo_empty),
        .o_full     (fifo_full),
        .o_overflow (fifo_ovf)
    );

    assign o_valid = !fifo_empty;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_fir_out_quant.sv
// tb_fir_out_quant: scoreboard bench for fir_out_quant with an arithmetic
// reference model (decimation, half-up rounding, clamp or wrap).
module tb_fir_out_quant;

    localparam int NB_DATA_IN = 19;
    localparam int NB_OUT     = 8;
    localparam int NB_DROP    = 11;
    localparam int FIFO_DEPTH = 4;
    localparam int NB_DECIM   = 4;
    localparam int STEP       = 1 << NB_DROP;
    localparam int HALF       = 1 << (NB_DROP - 1);
    localparam int OMAX       = (1 << (NB_OUT - 1)) - 1;
    localparam int OMIN       = -(1 << (NB_OUT - 1));

    logic                  i_clock = 1'b0;
    logic                  i_reset = 1'b1;
    logic [NB_DATA_IN-1:0] i_data  = '0;
    logic                  i_valid = 1'b0;
    logic [NB_DECIM-1:0]   i_decim = NB_DECIM'(1);
    logic [NB_OUT-1:0]     o_data;
    logic                  o_valid;
    logic                  i_ready = 1'b1;
    logic                  o_overflow;
    logic                  o_sat;

    always #5 i_clock = ~i_clock;

    fir_out_quant #(
        .NB_DATA_IN (NB_DATA_IN),
        .NB_OUT     (NB_OUT),
        .NB_DROP    (NB_DROP),
        .FIFO_DEPTH (FIFO_DEPTH),
        .NB_DECIM   (NB_DECIM)
    ) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .i_decim    (i_decim),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_overflow (o_overflow),
        .o_sat      (o_sat)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int sat_exp = 0;
    int mcnt = 0;
    int mact = 1;
    logic              hold_prev = 1'b0;
    logic [NB_OUT-1:0] prev_data = '0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // floor((x + 2^(NB_DROP-1)) / 2^NB_DROP), then clamp or wrap to NB_OUT bits.
    function automatic int quant(input int x, output bit s);
        int r;
        int q;
        int w;
        r = x + HALF;
        q = (r >= 0) ? r / STEP : -((-r + STEP - 1) / STEP);
        s = 1'b0;
`ifdef FIR_OQ_SAT_EN
        if (q > OMAX) begin
            s = 1'b1;
            return OMAX;
        end
        if (q < OMIN) begin
            s = 1'b1;
            return OMIN;
        end
        return q;
`else
        w = ((q % (1 << NB_OUT)) + (1 << NB_OUT)) % (1 << NB_OUT);
        return (w > OMAX) ? w - (1 << NB_OUT) : w;
`endif
    endfunction

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    // Model one valid input; returns whether the decimator keeps it.
    function automatic bit model_keep();
        int f;
        if (mcnt == 0) begin
            f = (int'(i_decim) == 0) ? 1 : int'(i_decim);
            mact = f;
            mcnt = (f > 1) ? 1 : 0;
            return 1'b1;
        end
        mcnt++;
        if (mcnt >= mact) mcnt = 0;
        return 1'b0;
    endfunction

    task automatic send(input int x, input bit dropped);
        bit s;
        int v;
        i_valid = 1'b1;
        i_data  = x[NB_DATA_IN-1:0];
        if (model_keep()) begin
            v = quant(x, s);
            if (!dropped) begin
                exp_q.push_back(v);
                if (s) sat_exp = 1;
            end
        end
        step();
        i_valid = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        exp_q.delete();
        mcnt = 0;
        mact = 1;
        sat_exp = 0;
        step();
        step();
        i_reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        i_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        step();
        step();
    endtask

    // Monitor: pops the scoreboard on every handshake and checks hold stability.
    always @(negedge i_clock) begin
        if (i_reset) begin
            hold_prev <= 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold", int'({o_valid, o_data}), int'({1'b1, prev_data}));
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got %0d expected none", $signed(o_data));
                end else begin
                    check("data", int'($signed(o_data)), exp_q.pop_front());
                end
            end
            hold_prev <= o_valid && !i_ready;
            prev_data <= o_data;
        end
    end

    initial begin
        int x;
        step();
        step();
        check("rst_valid", int'(o_valid), 0);
        check("rst_data", int'(o_data), 0);
        check("rst_ovf", int'(o_overflow), 0);
        check("rst_sat", int'(o_sat), 0);
        i_reset = 1'b0;
        step();

        // Rounding at decim=1.
        i_decim = NB_DECIM'(1);
        send(1024, 1'b0);
        send(-1024, 1'b0);
        send(2047, 1'b0);
        send(-3072, 1'b0);
        drain(50);

        // Saturation / wrap of the largest positive input.
        send(262143, 1'b0);
        drain(50);
`ifdef FIR_OQ_SAT_EN
        check("sat_flag", int'(o_sat), 1);
`else
        check("sat_flag", int'(o_sat), 0);
`endif
        check("sat_model", int'(o_sat), sat_exp);

        // Decimation by 4 on a continuous stream.
        do_reset();
        i_decim = NB_DECIM'(4);
        for (int k = 0; k < 16; k++) send(k * STEP, 1'b0);
        drain(50);

        // Overflow: fifth sample into a stalled full FIFO is dropped.
        do_reset();
        i_decim = NB_DECIM'(1);
        i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send(k * STEP, k == 5);
        repeat (4) step();
        check("ovf_set", int'(o_overflow), 1);
        check("ovf_valid", int'(o_valid), 1);
        drain(50);
        check("ovf_empty", int'(o_valid), 0);

        // Full FIFO with simultaneous push and pop keeps the push.
        do_reset();
        i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send(k * STEP, 1'b0);
        repeat (3) step();
        check("full_pre_ovf", int'(o_overflow), 0);
        send(5 * STEP, 1'b0);
        i_ready = 1'b1;
        step();
        check("full_pp_ovf", int'(o_overflow), 0);
        check("full_pp_valid", int'(o_valid), 1);
        drain(50);
        check("full_post_ovf", int'(o_overflow), 0);

        // Asynchronous reset with three entries stored.
        do_reset();
        i_ready = 1'b0;
        for (int k = 1; k <= 3; k++) send(k * STEP, 1'b0);
        repeat (3) step();
        check("mid_valid_pre", int'(o_valid), 1);
        #2;
        i_reset = 1'b1;
        exp_q.delete();
        mcnt = 0;
        mact = 1;
        sat_exp = 0;
        #1;
        check("mid_valid", int'(o_valid), 0);
        check("mid_data", int'(o_data), 0);
        check("mid_ovf", int'(o_overflow), 0);
        check("mid_sat", int'(o_sat), 0);
        step();
        step();
        i_reset = 1'b0;
        i_ready = 1'b1;
        i_decim = NB_DECIM'(3);
        send(7 * STEP, 1'b0);
        send(9 * STEP, 1'b0);
        send(5 * STEP, 1'b0);
        send(2 * STEP, 1'b0);
        drain(50);

        // Randomized traffic with factor changes and backpressure.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) i_decim = NB_DECIM'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1 && exp_q.size() < FIFO_DEPTH) begin
                x = int'($urandom_range(0, (1 << NB_DATA_IN) - 1)) - (1 << (NB_DATA_IN - 1));
                send(x, 1'b0);
            end else begin
                step();
            end
        end
        drain(100);
        check("rand_ovf", int'(o_overflow), 0);
        check("rand_sat", int'(o_sat), sat_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
